back_icon_str_receiver: RTL
===========================

Name: back_icon_str_receiver

Overview:
- Store-side receiver endpoint of the interconnect (icon) channels. It replaces the constant-1 tie-off of success_list.receiver_str in the backend.
- Snoops every icon channel and captures data when that channel is active, its receiver_list.receiver_str bit is set, and data_valid is high.
- Captured words go into a store buffer FIFO. The FIFO drains to the MMU over a valid/ready port.
- Per-channel success is reported back to the icon controller, which retries any channel that did not succeed.

Parameters:
- NUM_ICON_CHANNELS, 4, number of icon channels snooped.
- FIFO_DEPTH, 8, store buffer entries; must be a power of 2 and at least 2.
- LOG2_FIFO_DEPTH, $clog2(FIFO_DEPTH), pointer width.

Ports:
- clk, input, 1, single clock; all state on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- ch_active_i, input, [NUM_ICON_CHANNELS], channel active flags.
- ch_rx_str_i, input, [NUM_ICON_CHANNELS], receiver_list.receiver_str bit per channel.
- ch_data_i, input, type_exec_unit_data [NUM_ICON_CHANNELS], channel data.
- ch_data_valid_i, input, [NUM_ICON_CHANNELS], channel data_valid.
- ch_src_addr_i, input, type_exec_unit_addr [NUM_ICON_CHANNELS], channel src_addr.
- ch_success_o, output, [NUM_ICON_CHANNELS], drives success_list.receiver_str per channel.
- str_entry_o, output, type_str_rx_entry, head entry {data, src_addr} to the MMU.
- str_valid_o, output, 1, head entry valid.
- str_ready_i, input, 1, MMU accepts the head entry.
- flush_i, input, 1, synchronous discard of all buffered entries.
- occupancy_o, output, LOG2_FIFO_DEPTH+1, current entry count.

Behaviour:
- Reset (async, reset_n=0):
  - wr_ptr, rd_ptr and count clear to 0.
  - Outputs: str_valid_o=0, occupancy_o=0, ch_success_o=0, str_entry_o=0.
  - Reset takes effect mid-transfer; in-flight entries are lost and no success is asserted while reset is low.
- Request on channel i: req[i] = ch_active_i[i] & ch_rx_str_i[i] & ch_data_valid_i[i].
- ch_success_o is not required for channels with no request; it is 0 for them.
- Free slots: free = FIFO_DEPTH - count + (str_valid_o & str_ready_i). A same-cycle pop frees its slot for this cycle's writes.
- Grant:
  - Requesting channels are served in ascending index order. The first min(free, popcount(req)) of them are granted.
  - ch_success_o[i] = granted[i], combinational, in the same cycle as the request.
  - Ungranted requesters get success=0 and are retried by the controller.
- Write: at the clock edge each granted channel writes {ch_data_i[i], ch_src_addr_i[i]} at wr_ptr + k, where k is its rank among grants. wr_ptr then advances by the grant count.
- Pointers wrap modulo FIFO_DEPTH (natural LOG2 overflow).
- Read:
  - str_valid_o = (count != 0); str_entry_o = mem[rd_ptr]. Both are registered-state driven, so latency is capture edge +1 cycle.
  - Pop when str_valid_o & str_ready_i; rd_ptr advances by 1.
- Count update: count_next = count + grants - pop.
  - Full (count == FIFO_DEPTH, no pop): all success=0.
  - Empty: str_valid_o=0 and str_ready_i is ignored.
- flush_i:
  - Next cycle count=0 and rd_ptr=wr_ptr.
  - Grants in the flush cycle are suppressed (success=0) and the pop is ignored.
- Ordering: FIFO order = capture cycle order, then channel index within a cycle.
- State machine: none beyond the FIFO; the count saturates by construction.

Optional Feature:
- Macro: BACK_STR_RX_BYPASS_EN.
- With it defined: when count==0, no flush, and exactly the lowest granted channel exists with str_ready_i=1, that channel's entry is presented combinationally on str_entry_o with str_valid_o=1. It is consumed in the same cycle and never written to the FIFO. Zero-latency path.
- Without it: all entries pass through the FIFO with 1-cycle minimum latency. str_valid_o is purely register-driven.

Decomposition:
- pkg_dtypes gains:
  - typedef type_str_rx_entry {type_exec_unit_data data; type_exec_unit_addr src_addr;}
  - localparam STR_RX_FIFO_DEPTH = 8.
- Sub-module back_str_rx_fifo: multi-write (up to NUM_ICON_CHANNELS per cycle), single-read circular buffer with count, flush and wrap. The top level holds the request/grant priority logic and the success outputs.

Test Plan:
- Single channel: ch2 requests data 0xA5 for 1 cycle, str_ready_i=0 -> success[2]=1 that cycle; next cycle str_valid_o=1, entry data 0xA5, occupancy_o=1.
- All 4 channels request with count=6, FIFO_DEPTH=8 -> success=4'b0011; FIFO order ch0, ch1; occupancy 8; in the next cycle ch2/ch3 retry and get success=0 (full).
- Full FIFO with str_ready_i=1 and one request on ch1 -> success[1]=1 through same-cycle pop; occupancy stays 8.
- Wrap-around: push and pop 20 sequential values 1..20 with random str_ready_i -> output order 1..20 exact; pointers wrap with no loss.
- flush_i with 5 entries and a simultaneous request on ch0 -> success[0]=0; next cycle str_valid_o=0, occupancy 0.
- reset_n dropped asynchronously with 3 entries mid-drain -> str_valid_o=0 and ch_success_o=0 immediately; after release the FIFO is empty and a new capture works.

Source files
------------

// File: rtl/back_icon_str_receiver_pkg.sv
// Shared data types for the store-side icon receiver and its store buffer.
package back_icon_str_receiver_pkg;

  typedef logic [31:0] type_exec_unit_data;
  typedef logic [15:0] type_exec_unit_addr;

  // One store buffer entry as presented to the MMU.
  typedef struct packed {
    type_exec_unit_data data;
    type_exec_unit_addr src_addr;
  } type_str_rx_entry;

  localparam int STR_RX_FIFO_DEPTH   = 8;
  localparam int STR_RX_NUM_CHANNELS = 4;

endpackage

// File: rtl/back_str_rx_fifo.sv
// Store buffer: up to NUM_WR writes per cycle (already packed by rank),
// one read per cycle, synchronous flush, pointers wrap by natural overflow.
module back_str_rx_fifo
  import back_icon_str_receiver_pkg::*;
#(
  parameter int NUM_WR = 4,
  parameter int DEPTH  = 8,
  parameter int LOG2   = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(NUM_WR + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [CNT_W-1:0] wr_cnt_i,
  input  type_str_rx_entry wr_entry_i [NUM_WR],
  input  logic             pop_i,
  input  logic             flush_i,
  output type_str_rx_entry head_o,
  output logic             valid_o,
  output logic [LOG2:0]    count_o
);

  localparam int CW = LOG2 + 1;

  logic [LOG2-1:0]  wr_ptr_q, wr_ptr_d;
  logic [LOG2-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  type_str_rx_entry mem_q [DEPTH];
  type_str_rx_entry mem_d [DEPTH];

  // Next-state: flush drops everything by snapping rd_ptr onto wr_ptr;
  // otherwise entry k of the packed write list lands at wr_ptr + k.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush_i) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (CNT_W'(k) < wr_cnt_i) begin
          mem_d[wr_ptr_q + LOG2'(k)] = wr_entry_i[k];
        end
      end
      wr_ptr_d = wr_ptr_q + LOG2'(wr_cnt_i);
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + LOG2'(1);
      end
      count_d = count_q + CW'(wr_cnt_i) - CW'(pop_i);
    end
  end

  // Pointer and count registers; reset abandons any buffered entries.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only observable while count is non-zero.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign valid_o = (count_q != '0);
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/back_icon_str_receiver.sv
// Store-side receiver endpoint of the icon channels. Grants requesting
// channels in ascending index order up to the free store buffer space and
// reports per-channel success combinationally.
// Optional: BACK_STR_RX_BYPASS_EN adds a zero-latency path for the lowest
// granted channel when the buffer is empty and the MMU is ready.
//
// Handshake: str_valid_o/str_ready_i follow strict valid/ready; an entry
// transfers on a cycle where both are high, str_valid_o never depends on
// str_ready_i (except the bypass path), and str_ready_i is ignored while
// str_valid_o is low.
module back_icon_str_receiver
  import back_icon_str_receiver_pkg::*;
#(
  parameter int NUM_ICON_CHANNELS = STR_RX_NUM_CHANNELS,
  parameter int FIFO_DEPTH        = STR_RX_FIFO_DEPTH,
  parameter int LOG2_FIFO_DEPTH   = $clog2(FIFO_DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_ICON_CHANNELS-1:0] ch_active_i,
  input  logic [NUM_ICON_CHANNELS-1:0] ch_rx_str_i,
  input  type_exec_unit_data           ch_data_i [NUM_ICON_CHANNELS],
  input  logic [NUM_ICON_CHANNELS-1:0] ch_data_valid_i,
  input  type_exec_unit_addr           ch_src_addr_i [NUM_ICON_CHANNELS],
  output logic [NUM_ICON_CHANNELS-1:0] ch_success_o,
  output type_str_rx_entry             str_entry_o,
  output logic                         str_valid_o,
  input  logic                         str_ready_i,
  input  logic                         flush_i,
  output logic [LOG2_FIFO_DEPTH:0]     occupancy_o
);

  localparam int N      = NUM_ICON_CHANNELS;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
  localparam int FREE_W = LOG2_FIFO_DEPTH + 2;

  logic [N-1:0]           req;
  logic [N-1:0]           granted;
  logic [CNT_W-1:0]       n_grant;
  logic [FREE_W-1:0]      free_slots;
  logic                   pop;
  type_str_rx_entry       grant_list [N];
  type_str_rx_entry       fifo_wr_entry [N];
  logic [CNT_W-1:0]       fifo_wr_cnt;
  type_str_rx_entry       fifo_head;
  logic                   fifo_valid;
  logic [LOG2_FIFO_DEPTH:0] fifo_count;

  // Priority grant: lowest index first, bounded by free space (a same-cycle
  // pop counts as free). Grants are packed by rank for the store buffer.
  // Nothing is granted during reset or in a flush cycle.
  always_comb begin
    req        = ch_active_i & ch_rx_str_i & ch_data_valid_i;
    pop        = fifo_valid & str_ready_i & ~flush_i;
    free_slots = FREE_W'(FIFO_DEPTH) - FREE_W'(fifo_count) + FREE_W'(pop);
    granted    = '0;
    n_grant    = '0;
    for (int k = 0; k < N; k++) begin
      grant_list[k] = '0;
    end
    for (int i = 0; i < N; i++) begin
      if (req[i] && reset_n && !flush_i && (FREE_W'(n_grant) < free_slots)) begin
        granted[i]                          = 1'b1;
        grant_list[n_grant[IDX_W-1:0]].data     = ch_data_i[i];
        grant_list[n_grant[IDX_W-1:0]].src_addr = ch_src_addr_i[i];
        n_grant                             = n_grant + CNT_W'(1);
      end
    end
  end

`ifdef BACK_STR_RX_BYPASS_EN
  logic bypass;

  // Bypass: rank-0 grant goes straight to the MMU; remaining grants shift
  // down one rank into the store buffer.
  always_comb begin
    bypass = (fifo_count == '0) && !flush_i && str_ready_i && (n_grant != '0);
    fifo_wr_cnt = bypass ? (n_grant - CNT_W'(1)) : n_grant;
    for (int k = 0; k < N - 1; k++) begin
      fifo_wr_entry[k] = bypass ? grant_list[k + 1] : grant_list[k];
    end
    fifo_wr_entry[N-1] = bypass ? '0 : grant_list[N-1];
    str_valid_o = fifo_valid | bypass;
    str_entry_o = bypass ? grant_list[0] : fifo_head;
  end
`else
  // All grants pass through the store buffer; outputs are register-driven.
  always_comb begin
    fifo_wr_cnt   = n_grant;
    fifo_wr_entry = grant_list;
    str_valid_o   = fifo_valid;
    str_entry_o   = fifo_head;
  end
`endif

  assign ch_success_o = granted;
  assign occupancy_o  = fifo_count;

  back_str_rx_fifo #(
    .NUM_WR (N),
    .DEPTH  (FIFO_DEPTH),
    .LOG2   (LOG2_FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_cnt_i   (fifo_wr_cnt),
    .wr_entry_i (fifo_wr_entry),
    .pop_i      (pop),
    .flush_i    (flush_i),
    .head_o     (fifo_head),
    .valid_o    (fifo_valid),
    .count_o    (fifo_count)
  );

endmodule
